// File: rtl/fpro_mmio_ctrl.sv
// fpro_mmio_ctrl: FPro MMIO slot decoder with a 2-cycle registered read path.
// Define FPRO_MMIO_ERR_LOG_EN to add the error-log slot at index 63.
module fpro_mmio_ctrl #(
    parameter int          NUM_SLOTS   = 16,
    parameter logic [31:0] RD_IDLE_VAL = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fp_mmio_cs,
    input  logic                    fp_wr,
    input  logic                    fp_rd,
    input  logic [20:0]             fp_addr,
    input  logic [31:0]             fp_wr_data,
    output logic [31:0]             fp_rd_data,
    output logic [NUM_SLOTS-1:0]    slot_cs,
    output logic                    slot_wr,
    output logic                    slot_rd,
    output logic [4:0]              slot_reg_addr,
    output logic [31:0]             slot_wr_data,
    input  logic [32*NUM_SLOTS-1:0] slot_rd_data
);
    logic       req, in_range, ok, is_log, err, rd_only;
    logic [5:0] slot;
    logic       cap_v, cap_ok;
    logic [5:0] cap_slot;
    logic [31:0] slot_word, rd_word;

    assign slot     = fp_addr[10:5];
    assign req      = fp_mmio_cs & (fp_wr | fp_rd);
    assign in_range = fp_addr[20:11] == 10'd0;
    assign ok       = in_range && 32'(slot) < NUM_SLOTS;
    assign rd_only  = fp_rd & ~fp_wr;
    // A simultaneous write+read still strobes the write but is logged as an error.
    assign err      = req & ~is_log & (~ok | (fp_wr & fp_rd));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cs       <= '0;
            slot_wr       <= 1'b0;
            slot_rd       <= 1'b0;
            slot_reg_addr <= '0;
            slot_wr_data  <= '0;
            cap_v         <= 1'b0;
            cap_ok        <= 1'b0;
            cap_slot      <= '0;
            fp_rd_data    <= '0;
        end else begin
            slot_cs  <= (req && ok) ? NUM_SLOTS'(1) << slot : '0;
            slot_wr  <= req & ok & fp_wr;
            slot_rd  <= req & ok & rd_only;
            cap_v    <= req & rd_only;
            cap_ok   <= ok;
            cap_slot <= slot;
            if (req) begin
                slot_reg_addr <= fp_addr[4:0];
                slot_wr_data  <= fp_wr_data;
            end
            if (cap_v)
                fp_rd_data <= rd_word;
        end
    end

    always_comb begin
        slot_word = RD_IDLE_VAL;
        for (int k = 0; k < NUM_SLOTS; k++)
            if (cap_ok && cap_slot == 6'(k))
                slot_word = slot_rd_data[32*k +: 32];
    end

`ifdef FPRO_MMIO_ERR_LOG_EN
    logic        sticky_err, cap_log;
    logic [15:0] err_count;
    logic [20:0] first_err_addr;
    logic [4:0]  cap_reg;
    logic [31:0] log_word;

    assign is_log = in_range && slot == 6'd63;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sticky_err     <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            cap_log        <= 1'b0;
            cap_reg        <= '0;
        end else begin
            cap_log <= is_log;
            cap_reg <= fp_addr[4:0];
            if (req && is_log && fp_wr && fp_addr[4:0] == 5'd0) begin
                sticky_err     <= 1'b0;
                err_count      <= '0;
                first_err_addr <= '0;
            end else if (err) begin
                sticky_err <= 1'b1;
                if (err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
                if (!sticky_err)
                    first_err_addr <= fp_addr;
            end
        end
    end

    assign log_word = cap_reg == 5'd0 ? {sticky_err, 15'b0, err_count} :
                      cap_reg == 5'd1 ? {11'b0, first_err_addr} : 32'h0;
    assign rd_word  = cap_log ? log_word : slot_word;
`else
    assign is_log  = 1'b0;
    assign rd_word = slot_word;
`endif
endmodule
